// File: rtl/puf_pkg.sv
// Shared types and width helpers for the PUF pair-distance scheduler.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2,
    FIN   = 2'd3
  } ham_state_e;

  function automatic int calc_dw(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int calc_npairs(input int num_resp);
    return num_resp * (num_resp - 1) / 2;
  endfunction

  function automatic int calc_sw(input int width, input int num_resp);
    return $clog2(calc_npairs(num_resp) * width + 1);
  endfunction

endpackage

// File: rtl/puf_popcount.sv
// Combinational population count of an N-bit vector.
module puf_popcount #(
  parameter int N = 32,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  x,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(x[i]);
    end
  end

endmodule

// File: rtl/puf_pair_scheduler.sv
// Buffers NUM_RESP PUF responses and streams the Hamming distance of every pair (a<b).
// Optional running sum/min/max statistics are compiled in with PUF_HAM_STATS_EN.
module puf_pair_scheduler import puf_pkg::*; #(
  parameter int WIDTH    = 128,
  parameter int NUM_RESP = 4,
  parameter int CHUNK    = 32,
  localparam int DW = calc_dw(WIDTH),
  localparam int SW = calc_sw(WIDTH, NUM_RESP),
  localparam int IW = $clog2(NUM_RESP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    res_idx_a,
  output logic [IW-1:0]    res_idx_b,
  output logic [DW-1:0]    res_dist,
  output logic [SW-1:0]    sum_dist,
  output logic [DW-1:0]    min_dist,
  output logic [DW-1:0]    max_dist,
  output logic [1:0]       dbg_state
);

  localparam int CHUNKS = WIDTH / CHUNK;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PW     = $clog2(NUM_RESP + 1);
  localparam int PCW    = $clog2(CHUNK + 1);

  // Both handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; res_* outputs are stable while res_valid waits for res_ready.

  ham_state_e       state, state_n;
  logic [PW-1:0]    wr_ptr, wr_ptr_n;
  logic [IW-1:0]    a, a_n, b, b_n;
  logic [CW-1:0]    chunk, chunk_n;
  logic [DW-1:0]    acc, acc_n;
  logic             start_q;
  logic [WIDTH-1:0] mem [NUM_RESP];

  logic [WIDTH-1:0] diff;
  logic [CHUNK-1:0] slice;
  logic [PCW-1:0]   pc;
  logic             full, hs, last_pair, last_chunk;

  assign full       = (wr_ptr == PW'(NUM_RESP));
  assign hs         = (state == EMIT) && res_ready;
  assign last_pair  = (a == IW'(NUM_RESP - 2)) && (b == IW'(NUM_RESP - 1));
  assign last_chunk = (chunk == CW'(CHUNKS - 1));
  assign diff       = mem[a] ^ mem[b];
  assign slice      = diff[int'(chunk) * CHUNK +: CHUNK];

  puf_popcount #(.N(CHUNK)) u_pop (
    .x   (slice),
    .cnt (pc)
  );

  // start is registered so a request is taken only when raised in IDLE with a full buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      a       <= '0;
      b       <= '0;
      chunk   <= '0;
      acc     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      wr_ptr  <= wr_ptr_n;
      a       <= a_n;
      b       <= b_n;
      chunk   <= chunk_n;
      acc     <= acc_n;
      start_q <= start && (state == IDLE) && full;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && load_valid && load_ready) begin
      mem[wr_ptr[IW-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    a_n        = a;
    b_n        = b;
    chunk_n    = chunk;
    acc_n      = acc;
    load_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        load_ready = (wr_ptr < PW'(NUM_RESP));
        if (load_valid && load_ready) begin
          wr_ptr_n = wr_ptr + PW'(1);
        end
        if (start_q) begin
          a_n     = '0;
          b_n     = IW'(1);
          chunk_n = '0;
          acc_n   = '0;
          state_n = COUNT;
        end
      end
      COUNT: begin
        acc_n   = acc + DW'(pc);
        chunk_n = last_chunk ? '0 : chunk + CW'(1);
        if (last_chunk) begin
          state_n = EMIT;
        end
      end
      EMIT: begin
        res_valid = 1'b1;
        if (hs) begin
          chunk_n = '0;
          acc_n   = '0;
          if (last_pair) begin
            state_n = FIN;
          end else begin
            state_n = COUNT;
            if (b == IW'(NUM_RESP - 1)) begin
              a_n = a + IW'(1);
              b_n = a + IW'(2);
            end else begin
              b_n = b + IW'(1);
            end
          end
        end
      end
      FIN: begin
        done     = 1'b1;
        wr_ptr_n = '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign res_idx_a = res_valid ? a : '0;
  assign res_idx_b = res_valid ? b : '0;
  assign res_dist  = res_valid ? acc : '0;
  assign dbg_state = state;

`ifdef PUF_HAM_STATS_EN
  logic [SW-1:0] sum_q;
  logic [DW-1:0] min_q, max_q;
  logic [SW:0]   sum_ext;
  logic          stat_clr;

  assign sum_ext  = {1'b0, sum_q} + (SW + 1)'(acc);
  assign stat_clr = (state == IDLE) && start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      min_q <= DW'(WIDTH);
      max_q <= '0;
    end else if (stat_clr) begin
      sum_q <= '0;
      min_q <= DW'(WIDTH);
      max_q <= '0;
    end else if (hs) begin
      sum_q <= sum_ext[SW] ? '1 : sum_ext[SW-1:0];
      if (acc < min_q) min_q <= acc;
      if (acc > max_q) max_q <= acc;
    end
  end

  assign sum_dist = sum_q;
  assign min_dist = min_q;
  assign max_dist = max_q;
`else
  assign sum_dist = '0;
  assign min_dist = '0;
  assign max_dist = '0;
`endif

endmodule

// File: tb/tb_puf_pair_scheduler.sv
// Bench for puf_pair_scheduler: directed and random response sets checked against a pairwise model.
module tb_puf_pair_scheduler;

  localparam int W      = 128;
  localparam int N      = 4;
  localparam int C      = 32;
  localparam int CHUNKS = W / C;
  localparam int DW     = 8;
  localparam int SW     = 10;
  localparam int IW     = 2;
  localparam int EW     = 2 * IW + DW;
  localparam int BUDGET = 400;
`ifdef PUF_HAM_STATS_EN
  localparam int RST_MIN = W;
`else
  localparam int RST_MIN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid, load_ready;
  logic [W-1:0]  load_data;
  logic          start, busy, done;
  logic          res_valid, res_ready;
  logic [IW-1:0] res_idx_a, res_idx_b;
  logic [DW-1:0] res_dist;
  logic [SW-1:0] sum_dist;
  logic [DW-1:0] min_dist, max_dist;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0]  r [N];
  logic [EW-1:0] exp_q [$];
  int exp_sum, exp_min, exp_max;

  puf_pair_scheduler #(.WIDTH(W), .NUM_RESP(N), .CHUNK(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_idx_a  (res_idx_a),
    .res_idx_b  (res_idx_b),
    .res_dist   (res_dist),
    .sum_dist   (sum_dist),
    .min_dist   (min_dist),
    .max_dist   (max_dist),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ctrl"}, {load_ready, busy, done, res_valid}, 4'b1000);
    check_eq({tag, "_res"}, {res_idx_a, res_idx_b, res_dist}, 0);
    check_eq({tag, "_sum"}, sum_dist, 0);
    check_eq({tag, "_min"}, min_dist, RST_MIN);
    check_eq({tag, "_max"}, max_dist, 0);
  endtask

  // drivers: called just after a rising edge
  task automatic load_resp(input logic [W-1:0] d);
    load_valid = 1'b1; load_data = d;
    @(negedge clk);
    check_eq("load_rdy", load_ready, 1);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic load_set();
    for (int i = 0; i < N; i++) load_resp(r[i]);
  endtask

  task automatic randomize_set();
    for (int i = 0; i < N; i++) begin
      r[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i > 0 && $urandom_range(0, 3) == 0) r[i] = r[0];
    end
  endtask

  // reference model: every unordered pair in lexical order, distance by popcount of XOR
  task automatic build_model();
    exp_q.delete();
    exp_sum = 0; exp_min = W; exp_max = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        int d;
        d = $countones(r[i] ^ r[j]);
        exp_q.push_back({IW'(i), IW'(j), DW'(d)});
        exp_sum += d;
        if (d < exp_min) exp_min = d;
        if (d > exp_max) exp_max = d;
      end
    end
    if (exp_sum > (1 << SW) - 1) exp_sum = (1 << SW) - 1;
  endtask

  // scoreboard for one full scan; rand_ready toggles the sink randomly
  task automatic run_scan(input bit rand_ready);
    int cyc, seen, last_cyc, es, emn, emx;
    bit stalled;
    logic [EW-1:0] held, got, e;
    cyc = 0; seen = 0; last_cyc = 0; stalled = 1'b0; held = '0;
    build_model();
    start = 1'b1;
    res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (exp_q.size() > 0 && cyc < BUDGET) begin
      @(negedge clk);
      got = {res_idx_a, res_idx_b, res_dist};
      if (stalled) check_eq("stall_hold", {res_valid, got}, {1'b1, held});
      if (res_valid) begin
        if (seen == 0 && !stalled) check_eq("first_lat", cyc, CHUNKS + 1);
        if (!rand_ready && seen > 0) check_eq("pair_gap", cyc, last_cyc + CHUNKS + 1);
        if (res_ready) begin
          e = exp_q.pop_front();
          check_eq("pair", got, e);
          seen++; last_cyc = cyc; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = got;
        end
      end
      @(posedge clk);
      #1 cyc++;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end
    if (exp_q.size() > 0) check_eq("scan_timeout", exp_q.size(), 0);
    @(negedge clk);
    check_eq("done_pulse", {done, busy, res_valid}, 3'b110);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("done_end", {done, busy, load_ready}, 3'b001);
`ifdef PUF_HAM_STATS_EN
    es = exp_sum; emn = exp_min; emx = exp_max;
`else
    es = 0; emn = 0; emx = 0;
`endif
    check_eq("sum", sum_dist, es);
    check_eq("min", min_dist, emn);
    check_eq("max", max_dist, emx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_cnt, cyc, done_seen, busy_seen;
    do_reset();
    check_reset("reset");

    // start with a partially filled buffer is ignored
    r[0] = '0;
    r[1] = '1;
    r[2] = 128'hFF;
    r[3] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    load_resp(r[0]);
    load_resp(r[1]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("partial_start", {busy, load_ready}, 2'b01);
    @(posedge clk);
    #1;
    load_resp(r[2]);
    load_resp(r[3]);
    @(negedge clk);
    check_eq("full_ready", load_ready, 0);
    @(posedge clk);
    #1 load_valid = 1'b1; load_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk);
    #1 load_valid = 1'b0;

    run_scan(1'b0);
    load_set();
    run_scan(1'b1);

    repeat (3) begin
      randomize_set();
      load_set();
      run_scan(1'b1);
    end

    // reset during the COUNT phase of pair (1,2)
    randomize_set();
    load_set();
    hs_cnt = 0; cyc = 0;
    start = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (hs_cnt < 3 && cyc < BUDGET) begin
      @(negedge clk);
      if (res_valid && res_ready) hs_cnt++;
      @(posedge clk);
      #1 cyc++;
    end
    check_eq("mid_reach", hs_cnt, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset("mid_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    done_seen = 0; busy_seen = 0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
      @(posedge clk);
      #1 start = 1'b0;
    end
    check_eq("mid_no_done", done_seen, 0);
    check_eq("empty_start", busy_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
